// File: rtl/servo_pkg.sv
// servo_pkg
// Shared types and defaults for the servo motion sequencer.
//   servo_cmd_t   : one queued position command {target, step}
//   servo_state_e : sequencer FSM states
//   clamp_pw      : saturate a pulse width into a legal window
package servo_pkg;

  localparam int DEF_MIN_PW    = 500;
  localparam int DEF_MAX_PW    = 2500;
  localparam int DEF_CENTER_PW = 1500;

  typedef struct packed {
    logic [15:0] target;
    logic [7:0]  step;
  } servo_cmd_t;

  localparam int CMD_W = $bits(servo_cmd_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SLEW = 2'd2
  } servo_state_e;

  function automatic logic [15:0] clamp_pw(input logic [15:0] pw,
                                           input logic [15:0] lo,
                                           input logic [15:0] hi);
    if (pw < lo)      return lo;
    else if (pw > hi) return hi;
    else              return pw;
  endfunction

endpackage

// File: rtl/servo_cmd_fifo.sv
// servo_cmd_fifo
// Synchronous command queue with occupancy count and flush.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   i_flush          : empties the queue; wins over a same-cycle push/pop
//   i_push, i_data   : write request and packed servo_cmd_t (ignored when full)
//   i_pop            : read request (ignored when empty)
//   o_data           : head entry (valid while o_empty is low)
//   o_count          : number of stored entries
//   o_full, o_empty  : occupancy flags
module servo_cmd_fifo
  import servo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [CMD_W-1:0]         i_data,
  input  logic                     i_pop,
  output logic [CMD_W-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  // Full is taken from the registered count only, so a pop in the same
  // cycle never opens room for a push in that cycle.
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full && !i_flush;
  assign w_do_pop  = i_pop && !w_empty && !i_flush;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/servo_motion_seq.sv
// servo_motion_seq
// Servo PWM sequencer: queues position commands, slews the pulse width
// toward each target once per PWM frame and drives the registered PWM pin.
// Ports:
//   clk, rstn            : core clock, asynchronous active-low reset
//   enable               : 0 parks the output and freezes timing and FSM
//   cmd_valid/cmd_ready  : command push handshake
//   cmd_target, cmd_step : target pulse width (us), slew per frame (0 = jump)
//   flush                : empties the queue and aborts the active command
//   pwm_out              : registered servo PWM
//   cur_pw               : pulse width currently generated (us)
//   busy                 : active command or queued commands pending
//   fifo_count           : queued entries
//   frame_tick           : one-cycle pulse in the first cycle of each frame
module servo_motion_seq
  import servo_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int FRAME_US    = 20000,
  parameter int MIN_PW      = DEF_MIN_PW,
  parameter int MAX_PW      = DEF_MAX_PW,
  parameter int CENTER_PW   = DEF_CENTER_PW,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         enable,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [15:0]                  cmd_target,
  input  logic [7:0]                   cmd_step,
  input  logic                         flush,
  output logic                         pwm_out,
  output logic [15:0]                  cur_pw,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         frame_tick
);

  localparam int US_DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int PS_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(US_DIV - 1);
  localparam logic [15:0]     FRAME_LAST = 16'(FRAME_US - 1);
  localparam logic [15:0]     PW_MIN     = 16'(MIN_PW);
  localparam logic [15:0]     PW_MAX     = 16'(MAX_PW);
  localparam logic [15:0]     PW_CENTER  = 16'(CENTER_PW);

  logic [PS_W-1:0]  r_presc;
  logic [15:0]      r_frame_us;
  logic             r_frame_tick;
  logic             r_pwm;
  logic [15:0]      r_cur_pw;
  logic [15:0]      r_act_target;
  logic [7:0]       r_act_step;
  servo_state_e     r_state;

  servo_state_e     w_state_next;
  logic             w_us_wrap;
  logic             w_frame_wrap;
  logic             w_pop;
  logic             w_cur_upd;
  logic [15:0]      w_cur_next;
  servo_cmd_t       w_push_cmd;
  servo_cmd_t       w_head;
  logic [CMD_W-1:0] w_head_bits;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic signed [16:0] w_diff;
  logic [16:0]      w_abs;
  logic             w_reach;
  logic [15:0]      w_stepped;

  // Targets are saturated on the way in, so every queued target is legal.
  always_comb begin
    w_push_cmd        = '0;
    w_push_cmd.target = clamp_pw(cmd_target, PW_MIN, PW_MAX);
    w_push_cmd.step   = cmd_step;
  end

  servo_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (flush),
    .i_push  (cmd_valid),
    .i_data  (w_push_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_count (fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_head    = servo_cmd_t'(w_head_bits);
  assign cmd_ready = !w_fifo_full;

  // Timebase. With enable low both counters sit at 0 so the next frame
  // starts cleanly as soon as enable returns.
  assign w_us_wrap    = enable && (r_presc == PS_LAST);
  assign w_frame_wrap = w_us_wrap && (r_frame_us == FRAME_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc    <= '0;
      r_frame_us <= '0;
    end else if (!enable) begin
      r_presc    <= '0;
      r_frame_us <= '0;
    end else if (w_us_wrap) begin
      r_presc    <= '0;
      r_frame_us <= (r_frame_us == FRAME_LAST) ? 16'd0 : r_frame_us + 16'd1;
    end else begin
      r_presc    <= r_presc + 1'b1;
    end
  end

  // frame_tick is high in the first cycle with frame_us at 0; the registered
  // compare then raises pwm_out one cycle later, and because cur_pw changes
  // at the end of the tick cycle the whole high phase uses the new width.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_tick <= 1'b0;
      r_pwm        <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_wrap;
      r_pwm        <= enable && (r_frame_us < r_cur_pw);
    end
  end

  // Slew arithmetic in 17-bit signed so the sign of (target - cur) is exact.
  // A move that does not reach the target cannot overshoot it, and both
  // endpoints are legal, so the result stays inside the legal window.
  assign w_diff    = $signed({1'b0, r_act_target}) - $signed({1'b0, r_cur_pw});
  assign w_abs     = w_diff[16] ? 17'(-w_diff) : 17'(w_diff);
  assign w_reach   = (r_act_step == 8'd0) || (w_abs <= {9'd0, r_act_step});
  assign w_stepped = w_diff[16] ? (r_cur_pw - {8'd0, r_act_step})
                                : (r_cur_pw + {8'd0, r_act_step});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and datapath strobes. flush wins over everything, and with
  // enable low the FSM holds its state.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_cur_upd    = 1'b0;
    w_cur_next   = r_cur_pw;
    if (flush) begin
      w_state_next = IDLE;
    end else if (enable) begin
      case (r_state)
        IDLE: begin
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_state_next = LOAD;
          end
        end
        LOAD: w_state_next = SLEW;
        SLEW: begin
          if (r_frame_tick) begin
            w_cur_upd = 1'b1;
            if (w_reach) begin
              w_cur_next   = r_act_target;
              w_state_next = IDLE;
            end else begin
              w_cur_next = w_stepped;
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_act_target <= PW_CENTER;
      r_act_step   <= '0;
    end else if (w_pop) begin
      r_act_target <= w_head.target;
      r_act_step   <= w_head.step;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          r_cur_pw <= PW_CENTER;
    else if (w_cur_upd) r_cur_pw <= w_cur_next;
  end

  assign pwm_out    = r_pwm;
  assign cur_pw     = r_cur_pw;
  assign frame_tick = r_frame_tick;
  assign busy       = (r_state != IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_servo_motion_seq.sv
// tb_servo_motion_seq
// Directed bench for servo_motion_seq with a 2 MHz clock model (2 cycles
// per us) and a 100 us frame, so one frame is 200 clock cycles.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_servo_motion_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_target = '0;
  logic [7:0]  cmd_step = '0;
  logic        flush = 1'b0;
  logic        cmd_ready;
  logic        pwm_out;
  logic [15:0] cur_pw;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        frame_tick;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  servo_motion_seq #(
    .CLK_FREQ_HZ (2_000_000),
    .FRAME_US    (100),
    .MIN_PW      (10),
    .MAX_PW      (90),
    .CENTER_PW   (50),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .flush      (flush),
    .pwm_out    (pwm_out),
    .cur_pw     (cur_pw),
    .busy       (busy),
    .fifo_count (fifo_count),
    .frame_tick (frame_tick)
  );

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Drives one cycle of inputs from a falling edge and returns at the next
  // falling edge with the inputs released.
  task automatic applyStimulus(input logic valid, input logic [15:0] target,
                               input logic [7:0] step, input logic fl);
    cmd_valid  = valid;
    cmd_target = target;
    cmd_step   = step;
    flush      = fl;
    @(negedge clk);
    cmd_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  // Returns on the falling edge where frame_tick is high.
  task automatic waitTick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 600);
    if (!frame_tick) checkOutput("tick_timeout", 0, 1);
  endtask

  // Returns one cycle after a tick, when cur_pw has taken its new value.
  task automatic stepFrame();
    waitTick();
    @(negedge clk);
  endtask

  // Counts pwm_out high cycles in the 199 cycles following a tick sample,
  // stopping one cycle before the next tick.
  task automatic countHigh(output int highCnt);
    highCnt = 0;
    repeat (199) begin
      @(negedge clk);
      if (pwm_out) highCnt++;
    end
  endtask

  task automatic measureHigh(output int highCnt);
    waitTick();
    countHigh(highCnt);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   hi;
    logic pwmSeen;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_pwm", pwm_out, 0);
    checkOutput("rst_cur_pw", cur_pw, 50);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_frame_tick", frame_tick, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    rstn = 1'b1;
    @(negedge clk);

    // Scenario 1: idle output, 50 us pulse in a 100 us frame.
    $display("[TB] scenario 1: enable with centre pulse");
    enable = 1'b1;
    waitTick();
    checkOutput("s1_pwm_at_tick", pwm_out, 0);
    countHigh(hi);
    checkOutput("s1_high_cycles", hi, 100);
    @(negedge clk);
    checkOutput("s1_frame_period", frame_tick, 1);
    checkOutput("s1_cur_pw", cur_pw, 50);
    checkOutput("s1_busy", busy, 0);

    // Scenario 2: slew 50 -> 80 in steps of 10.
    $display("[TB] scenario 2: slew to 80 step 10");
    applyStimulus(1'b1, 16'd80, 8'd10, 1'b0);
    checkOutput("s2_count_after_push", fifo_count, 1);
    checkOutput("s2_busy_after_push", busy, 1);
    @(negedge clk);
    checkOutput("s2_count_after_pop", fifo_count, 0);
    checkOutput("s2_busy_loading", busy, 1);
    stepFrame();
    checkOutput("s2_cur_pw_60", cur_pw, 60);
    measureHigh(hi);
    checkOutput("s2_cur_pw_70", cur_pw, 70);
    checkOutput("s2_high_cycles_70", hi, 140);
    stepFrame();
    checkOutput("s2_cur_pw_80", cur_pw, 80);
    checkOutput("s2_busy_done", busy, 0);

    // Scenario 3: jumps with clamping at both ends.
    $display("[TB] scenario 3: clamped jumps");
    applyStimulus(1'b1, 16'd5, 8'd0, 1'b0);
    stepFrame();
    checkOutput("s3_cur_pw_min_clamp", cur_pw, 10);
    checkOutput("s3_busy", busy, 0);
    measureHigh(hi);
    checkOutput("s3_high_cycles_10", hi, 20);
    applyStimulus(1'b1, 16'd1000, 8'd0, 1'b0);
    stepFrame();
    checkOutput("s3_cur_pw_max_clamp", cur_pw, 90);

    // Scenario 4: fill the queue while disabled.
    $display("[TB] scenario 4: queue fill with enable low");
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("s4_pwm_parked", pwm_out, 0);
    pwmSeen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid  = 1'b1;
      cmd_target = 16'(20 + 10 * i);
      cmd_step   = 8'd3;
      @(negedge clk);
      pwmSeen = pwmSeen | pwm_out;
      if (i == 2) checkOutput("s4_ready_after_3", cmd_ready, 1);
      if (i == 3) checkOutput("s4_ready_after_4", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    checkOutput("s4_count_full", fifo_count, 4);
    checkOutput("s4_ready_full", cmd_ready, 0);
    checkOutput("s4_busy_queued", busy, 1);
    checkOutput("s4_pwm_never_high", pwmSeen, 0);
    checkOutput("s4_cur_pw_frozen", cur_pw, 90);
    applyStimulus(1'b0, 16'd0, 8'd0, 1'b1);
    checkOutput("s4_count_flushed", fifo_count, 0);
    checkOutput("s4_busy_flushed", busy, 0);
    checkOutput("s4_ready_flushed", cmd_ready, 1);

    // Return to centre before the flush-during-slew case.
    enable = 1'b1;
    applyStimulus(1'b1, 16'd50, 8'd0, 1'b0);
    stepFrame();
    checkOutput("s5_cur_pw_start", cur_pw, 50);

    // Scenario 5: flush mid-slew with a simultaneous push.
    $display("[TB] scenario 5: flush during slew");
    applyStimulus(1'b1, 16'd90, 8'd5, 1'b0);
    applyStimulus(1'b1, 16'd20, 8'd0, 1'b0);
    stepFrame();
    checkOutput("s5_cur_pw_55", cur_pw, 55);
    stepFrame();
    checkOutput("s5_cur_pw_60", cur_pw, 60);
    stepFrame();
    checkOutput("s5_cur_pw_65", cur_pw, 65);
    checkOutput("s5_count_pending", fifo_count, 1);
    checkOutput("s5_busy_slewing", busy, 1);
    applyStimulus(1'b1, 16'd30, 8'd0, 1'b1);
    checkOutput("s5_count_after_flush", fifo_count, 0);
    checkOutput("s5_busy_after_flush", busy, 0);
    stepFrame();
    checkOutput("s5_cur_pw_hold_1", cur_pw, 65);
    stepFrame();
    checkOutput("s5_cur_pw_hold_2", cur_pw, 65);
    checkOutput("s5_busy_still_idle", busy, 0);

    // Scenario 6: asynchronous reset during the high phase.
    $display("[TB] scenario 6: reset while pwm high");
    applyStimulus(1'b1, 16'd30, 8'd5, 1'b0);
    applyStimulus(1'b1, 16'd40, 8'd5, 1'b0);
    checkOutput("s6_pwm_high_before", pwm_out, 1);
    checkOutput("s6_count_before", fifo_count, 1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("s6_pwm_async_low", pwm_out, 0);
    checkOutput("s6_count_in_reset", fifo_count, 0);
    checkOutput("s6_cur_pw_in_reset", cur_pw, 50);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("s6_cur_pw_after", cur_pw, 50);
    checkOutput("s6_count_after", fifo_count, 0);
    checkOutput("s6_busy_after", busy, 0);
    checkOutput("s6_ready_after", cmd_ready, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/servo_motion_seq.md
# servo_motion_seq

Sequences the servo PWM datapath: accepts queued position commands from the bus-side peripheral registers, slews the servo pulse width toward each target at a commanded rate once per PWM frame, and drives the `SERVO_PWM` pin. Sits inside `veerwolf_core` between the servo register block and the board-level `servo_pwm_out`, running on `clk_core` (25 MHz).

## Interface
Parameters:
- `CLK_FREQ_HZ`, 25_000_000, core clock; must be an integer multiple of 1 MHz.
- `FRAME_US`, 20000, PWM frame period in µs (50 Hz).
- `MIN_PW`, 500, minimum legal pulse width in µs.
- `MAX_PW`, 2500, maximum legal pulse width in µs.
- `CENTER_PW`, 1500, pulse width after reset, in µs.
- `FIFO_DEPTH`, 4, command queue entries; power of two.

Ports:
- `clk` in 1: core clock.
- `rstn` in 1: asynchronous, active-low reset.
- `enable` in 1: level; 0 parks the output.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: queue not full.
- `cmd_target` in 16: target pulse width, µs.
- `cmd_step` in 8: slew per frame, µs; 0 means jump.
- `flush` in 1: one-cycle pulse; empties the queue and aborts the active command.
- `pwm_out` out 1: registered servo PWM.
- `cur_pw` out 16: pulse width currently being generated, µs.
- `busy` out 1: active command or queue non-empty.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: queued entries.
- `frame_tick` out 1: one-cycle pulse at each frame start.

## Operation
- The µs prescaler counts `0..CLK_FREQ_HZ/1e6-1`. The frame counter `frame_us` advances on each µs wrap and wraps at `FRAME_US-1`.
- `frame_tick` is asserted in the cycle where `frame_us` wraps to 0. `cur_pw` updates only in that cycle.
- `pwm_out` is high while `enable && frame_us < cur_pw`.
- Queue entries are `{target, step}`. Targets are clamped to `[MIN_PW, MAX_PW]` at push.
- FSM `IDLE`, `LOAD`, `SLEW`:
  - `IDLE`: if the queue is non-empty, pop the head into `act_target`/`act_step` and go to `LOAD`.
  - `LOAD`: one cycle, then `SLEW`.
  - `SLEW`: on `frame_tick`:
    - If `act_step==0` or `|act_target-cur_pw| <= act_step`, set `cur_pw = act_target` and go to `IDLE`.
    - Otherwise move `cur_pw` by `act_step` toward the target.
- Arithmetic: 17-bit signed difference. Results never leave `[MIN_PW, MAX_PW]`.
- `enable=0`: prescaler and frame counter held at 0, `pwm_out=0`, FSM frozen. The queue still accepts pushes.
- `flush`: queue emptied and FSM to `IDLE`. `cur_pw` keeps its value. Takes priority over a same-cycle push (the push is dropped) and over a same-cycle slew update.

## Timing
- Reset values:
  - `pwm_out=0`, `cur_pw=CENTER_PW`, `busy=0`, `fifo_count=0`, `frame_tick=0`, `cmd_ready=1`.
  - FSM in `IDLE`, all counters 0.
- Push handshake:
  - A push is accepted when `cmd_valid && cmd_ready` at a rising edge.
  - `cmd_ready = (fifo_count != FIFO_DEPTH)` is derived from registered state only.
  - When the queue is full, a pop in the same cycle does not enable a push in that cycle.
- Latency: a push to an empty queue with the FSM in `IDLE` is popped 1 cycle after acceptance. The first `cur_pw` change occurs at the next `frame_tick` after `LOAD`.
- `pwm_out` is registered. Its rising edge comes 1 cycle after `frame_tick`, and its high time is exactly `cur_pw` µs.
- Reset asserted mid-frame: `pwm_out` drops asynchronously and the queue contents are lost.

## Structure
- Shared package `servo_pkg`:
  - `typedef` `servo_cmd_t` (`target[15:0]`, `step[7:0]`).
  - FSM enum `servo_state_e`.
  - Constants for `MIN_PW`/`MAX_PW`/`CENTER_PW` defaults.
- One natural sub-module: `servo_cmd_fifo`, a synchronous FIFO of `servo_cmd_t` with count, full/empty and flush.
- Prescaler, frame counter, FSM and PWM compare stay in the top module.

## Test plan
All scenarios use `CLK_FREQ_HZ=2_000_000` and `FRAME_US=100` for sim speed, with `MIN_PW=10`, `MAX_PW=90`, `CENTER_PW=50`.
1. Reset, then `enable=1` -> `pwm_out` high 100 cycles per 200-cycle frame; `cur_pw=50`; `busy=0`.
2. Push `{target 80, step 10}` -> `cur_pw` 60, 70, 80 on three successive `frame_tick`s, then `busy=0`.
3. Push `{target 5, step 0}` -> `cur_pw=10` (clamped) at the first `frame_tick`.
4. Push 4 commands back-to-back with `enable=0` -> `cmd_ready=0` after the 4th, the 5th push is refused, `fifo_count=4`, and `pwm_out` stays 0.
5. During a slew to 90 (step 5) from 50, pulse `flush` at `cur_pw=65` -> `busy=0`, `fifo_count=0`, and `cur_pw` holds 65 for the following frames.
6. Assert `rstn=0` while `pwm_out=1` -> `pwm_out=0` immediately; after release `cur_pw=50` and `fifo_count=0`.
